regfile_read_arbiter: RTL and testbench
=======================================

// Module: regfile_read_arbiter
// PURPOSE
//  Shares one 64-bit register-file read port (32x64 mux, 5-bit select) between NREQ requesters.
//  Round-robin arbitration with optional locked bursts.
//  Drives the port select combinationally and returns registered read data one cycle after grant.
//  Sits between the decode/debug requesters and the register-file read mux.
// PARAMETERS
//  NREQ       3  number of requesters (2..8)
//  MAX_BURST  4  max consecutive grants to one locked owner (>=1)
//  ZERO_XZR   1  1: reads of address 31 return 64'h0 regardless of port_data
// PORTS
//  clk        in   1          clock, all state updates on posedge
//  reset      in   1          synchronous, active-high
//  req        in   NREQ       request per requester; hold with addr until gnt
//  lock       in   NREQ       request burst ownership (sampled with req)
//  addr       in   NREQx5     read address per requester
//  gnt        out  NREQ       one-hot grant, combinational, same cycle as req
//  port_sel   out  5          select to register-file read mux
//  port_data  in   64         data from register-file read mux
//  rdata      out  64         registered read data
//  rvalid     out  NREQ       one-hot, marks owner of rdata, 1 cycle after gnt
// BEHAVIOUR
//  - Transfer: a read is consumed when req[i]&gnt[i] at a posedge; at most one gnt bit per cycle.
//  - Port select: port_sel = addr[winner] while any gnt is high, else 5'd0.
//  - Read data: port_data (or 0 when ZERO_XZR && addr==31) is registered into rdata.
//  - rvalid: rvalid <= gnt. Latency is exactly 1 cycle; rdata holds its value while rvalid==0.
//  - Reset: state=ARB, ptr=0, owner=0, cnt=0, rdata=0, rvalid=0.
//    gnt=0 and port_sel=0 in any cycle where reset=1.
//  - Reset mid-burst or mid-read: the in-flight rvalid is dropped and the burst is abandoned.
//  - FSM ARB:
//    * Winner = first asserted req scanning ptr, ptr+1, ... mod NREQ.
//    * On grant: ptr <= winner+1 mod NREQ.
//    * If lock[winner]: state <= LOCKED, owner <= winner, cnt <= 1.
//    * No req: no grant, state and ptr hold.
//  - FSM LOCKED:
//    * Only owner is eligible; other req bits are ignored, not lost (they stay pending).
//    * req[owner]&lock[owner]&cnt<MAX_BURST: grant, cnt++.
//    * req[owner]&lock[owner]&cnt==MAX_BURST: no grant this cycle.
//      state <= ARB, ptr <= owner+1, so others win next.
//    * req[owner]&!lock[owner]: final grant, state <= ARB.
//    * !req[owner]: no grant, state <= ARB (lock abandoned).
//  - MAX_BURST==1: lock has no effect beyond one grant; LOCKED always exits on its first cycle with no grant.
//  - Pointer wrap: ptr==NREQ-1 advances to 0.
//    Arbitration is fair: any held req is granted within NREQ*(MAX_BURST+1) cycles.
// STRUCTURE
//  - Package regfile_arb_pkg:
//    * ADDR_W=5, DATA_W=64, XZR_ADDR=5'd31.
//    * typedef enum logic {ARB, LOCKED} arb_state_t.
//  - Sub-module rr_priority_pick:
//    * Combinational.
//    * Inputs req[NREQ], ptr.
//    * Outputs onehot[NREQ], idx, any.
//  - Top holds the FSM, ptr/owner/cnt registers, rdata/rvalid registers and the XZR zero mux.
// TESTING
//  1. Reset with req=3'b111 held -> gnt=0, rvalid=0, rdata=0.
//     First cycle after release: gnt=001, port_sel=addr[0].
//  2. req=111, lock=0, addr={5,9,2}, port_data=regs[sel]:
//     - gnt sequence 001,010,100,001.
//     - rvalid follows one cycle later with rdata=regs[2],regs[9],regs[5],...
//  3. req0 held with lock0=1, req1 held, MAX_BURST=4:
//     - gnt=001 x4, then one idle cycle.
//     - Then gnt=010; rvalid=001 x4 then 010.
//  4. Owner drops lock on its 2nd grant -> exactly 2 owner grants, then ARB.
//     Owner drops req mid-burst -> no grant that cycle, other requester granted next.
//  5. addr=31, port_data=64'hDEAD_BEEF_0000_0001, ZERO_XZR=1 -> rdata=0 with rvalid.
//     ZERO_XZR=0 -> rdata=port_data.
//  6. reset asserted the cycle after a grant inside LOCKED:
//     - rvalid=0 next cycle, state=ARB, ptr=0.
//     - Pending reqs re-arbitrated from requester 0.

Source files
------------

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Address 31 is the architectural zero register when zeroing is enabled.
  function automatic logic is_xzr(input logic [ADDR_W-1:0] a);
    return a == XZR_ADDR;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester/read-port bundle between the requesters, the arbiter and the register-file mux.
interface regfile_read_arbiter_if #(
  parameter int NREQ = 3
);
  import regfile_arb_pkg::*;

  // Handshake: requester i holds req[i] (with lock[i] and addr[i]) until it sees gnt[i];
  // a read transfers on the posedge where req[i] & gnt[i]. rvalid[i] is high exactly one
  // cycle later with rdata; there is no backpressure on the return path.
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             lock;
  logic [NREQ-1:0][ADDR_W-1:0] addr;
  logic [NREQ-1:0]             gnt;
  logic [ADDR_W-1:0]           port_sel;
  logic [DATA_W-1:0]           port_data;
  logic [DATA_W-1:0]           rdata;
  logic [NREQ-1:0]             rvalid;

  modport master (
    output req, lock, addr, port_data,
    input  gnt, port_sel, rdata, rvalid
  );

  modport slave (
    input  req, lock, addr, port_data,
    output gnt, port_sel, rdata, rvalid
  );

endinterface

// File: rtl/regfile_read_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first asserted request at or after ptr, wrapping mod NREQ.
module rr_priority_pick #(
  parameter  int NREQ  = 3,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NREQ)) pos = pos - (PTR_W+1)'(NREQ);
      if (!any && req[pos[PTR_W-1:0]]) begin
        any                    = 1'b1;
        idx                    = pos[PTR_W-1:0];
        onehot[pos[PTR_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one 64-bit register-file read port between NREQ requesters with round-robin
// arbitration, optional locked bursts, and registered read data one cycle after grant.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int NREQ      = 3,
  parameter  int MAX_BURST = 4,
  parameter  bit ZERO_XZR  = 1'b1,
  localparam int PTR_W     = $clog2(NREQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_read_arbiter_if.slave bus,
  output arb_state_t            dbg_state,
  output logic [PTR_W-1:0]      dbg_ptr,
  output logic [PTR_W-1:0]      dbg_owner,
  output logic [CNT_W-1:0]      dbg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  // With single-grant bursts the locked state never issues a grant, even a final one.
  localparam bit FINAL_GRANT_OK = (MAX_BURST > 1);

  arb_state_t        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [NREQ-1:0]   rvalid_q;

  logic [NREQ-1:0]   pick_onehot;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;

  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  win;
  logic              own_req;
  logic              own_lock;
  logic              burst_room;
  logic [DATA_W-1:0] rd_next;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NREQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign own_req    = bus.req[owner];
  assign own_lock   = bus.lock[owner];
  assign burst_room = (cnt < CNT_MAX);

  always_comb begin
    gnt = '0;
    win = '0;
    if (!reset) begin
      if (state == ARB) begin
        gnt = pick_onehot;
        win = pick_idx;
      end else if (own_req && (own_lock ? burst_room : FINAL_GRANT_OK)) begin
        gnt[owner] = 1'b1;
        win        = owner;
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.port_sel = (|gnt) ? bus.addr[win] : '0;
  assign rd_next      = (ZERO_XZR && is_xzr(bus.port_sel)) ? '0 : bus.port_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
      if (|gnt) rdata_q <= rd_next;
      case (state)
        ARB: begin
          if (pick_any) begin
            ptr <= ptr_next(pick_idx);
            if (bus.lock[pick_idx]) begin
              state <= LOCKED;
              owner <= pick_idx;
              cnt   <= CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          if (own_req && own_lock && burst_room) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            state <= ARB;
            // Burst hit its cap while still locked: force the others ahead next cycle.
            if (own_req && own_lock) ptr <= ptr_next(owner);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

  assign dbg_state = state;
  assign dbg_ptr   = ptr;
  assign dbg_owner = owner;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: three instances (burst 4 / zeroing on, burst 4 / zeroing off,
// burst 1 / zeroing on) share one stimulus stream and are checked against a behavioural model.
module tb_regfile_read_arbiter;
  import regfile_arb_pkg::*;

  localparam int N  = 3;
  localparam int NI = 3;
  localparam logic [63:0] XZR_PATTERN = 64'hDEAD_BEEF_0000_0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- stimulus and register file ----------------
  logic [N-1:0]      req_d;
  logic [N-1:0]      lock_d;
  logic [N-1:0][4:0] addr_d;
  logic [63:0]       regs [32];

  regfile_read_arbiter_if #(.NREQ(N)) ifa ();
  regfile_read_arbiter_if #(.NREQ(N)) ifb ();
  regfile_read_arbiter_if #(.NREQ(N)) ifc ();

  assign ifa.req = req_d;  assign ifa.lock = lock_d;  assign ifa.addr = addr_d;
  assign ifb.req = req_d;  assign ifb.lock = lock_d;  assign ifb.addr = addr_d;
  assign ifc.req = req_d;  assign ifc.lock = lock_d;  assign ifc.addr = addr_d;
  assign ifa.port_data = regs[ifa.port_sel];
  assign ifb.port_data = regs[ifb.port_sel];
  assign ifc.port_data = regs[ifc.port_sel];

  arb_state_t st_a, st_b, st_c;
  logic [1:0] ptr_a, ptr_b, ptr_c, own_a, own_b, own_c;
  logic [2:0] cnt_a, cnt_b;
  logic       cnt_c;

  regfile_read_arbiter #(.NREQ(N), .MAX_BURST(4), .ZERO_XZR(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave),
    .dbg_state(st_a), .dbg_ptr(ptr_a), .dbg_owner(own_a), .dbg_cnt(cnt_a)
  );
  regfile_read_arbiter #(.NREQ(N), .MAX_BURST(4), .ZERO_XZR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave),
    .dbg_state(st_b), .dbg_ptr(ptr_b), .dbg_owner(own_b), .dbg_cnt(cnt_b)
  );
  regfile_read_arbiter #(.NREQ(N), .MAX_BURST(1), .ZERO_XZR(1'b1)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc.slave),
    .dbg_state(st_c), .dbg_ptr(ptr_c), .dbg_owner(own_c), .dbg_cnt(cnt_c)
  );

  logic [N-1:0] o_gnt [NI];
  logic [N-1:0] o_rv  [NI];
  logic [4:0]   o_sel [NI];
  logic [63:0]  o_rd  [NI];
  assign o_gnt[0] = ifa.gnt;  assign o_rv[0] = ifa.rvalid;  assign o_sel[0] = ifa.port_sel;  assign o_rd[0] = ifa.rdata;
  assign o_gnt[1] = ifb.gnt;  assign o_rv[1] = ifb.rvalid;  assign o_sel[1] = ifb.port_sel;  assign o_rd[1] = ifb.rdata;
  assign o_gnt[2] = ifc.gnt;  assign o_rv[2] = ifc.rvalid;  assign o_sel[2] = ifc.port_sel;  assign o_rd[2] = ifc.rdata;

  // ---------------- reference model ----------------
  int          mb [NI];
  bit          zx [NI];
  bit          m_lk  [NI];
  int          m_own [NI];
  int          m_cnt [NI];
  int          m_ptr [NI];
  logic [N-1:0] m_rv [NI];
  logic [63:0] m_rd  [NI];
  logic [N-1:0] e_gnt [NI];
  logic [4:0]  e_sel [NI];
  int          e_win [NI];
  logic [63:0] exp_q [$];
  logic [N-1:0] last_gnt [NI];
  logic [4:0]  last_sel [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Who may read this cycle: a free arbiter picks round-robin from its pointer; an
  // arbiter owned by a burst serves only the owner while the burst still has room.
  task automatic model_comb();
    for (int k = 0; k < NI; k++) begin
      e_gnt[k] = '0;
      e_sel[k] = '0;
      e_win[k] = 0;
      if (!reset) begin
        if (!m_lk[k]) begin
          for (int j = 0; j < N; j++) begin
            int c;
            c = (m_ptr[k] + j) % N;
            if (req_d[c] && e_gnt[k] == '0) begin
              e_gnt[k][c] = 1'b1;
              e_win[k]    = c;
            end
          end
        end else begin
          int o;
          o = m_own[k];
          if (req_d[o] && ((lock_d[o] && m_cnt[k] < mb[k]) || (!lock_d[o] && mb[k] > 1))) begin
            e_gnt[k][o] = 1'b1;
            e_win[k]    = o;
          end
        end
        if (e_gnt[k] != '0) e_sel[k] = addr_d[e_win[k]];
      end
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        m_lk[k] = 1'b0; m_own[k] = 0; m_cnt[k] = 0; m_ptr[k] = 0;
        m_rv[k] = '0;   m_rd[k] = '0;
        if (k == 0) exp_q.delete();
      end else begin
        m_rv[k] = e_gnt[k];
        if (e_gnt[k] != '0) begin
          m_rd[k] = (zx[k] && e_sel[k] == 5'd31) ? 64'h0 : regs[e_sel[k]];
          if (k == 0) exp_q.push_back(m_rd[k]);
        end
        if (!m_lk[k]) begin
          if (e_gnt[k] != '0) begin
            m_ptr[k] = (e_win[k] + 1) % N;
            if (lock_d[e_win[k]]) begin
              m_lk[k] = 1'b1; m_own[k] = e_win[k]; m_cnt[k] = 1;
            end
          end
        end else begin
          int o;
          o = m_own[k];
          if (e_gnt[k] != '0 && lock_d[o]) m_cnt[k]++;
          else begin
            m_lk[k] = 1'b0;
            if (req_d[o] && lock_d[o]) m_ptr[k] = (o + 1) % N;
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set at the negedge; combinational outputs are sampled 1ns later and
  // registered outputs 1ns after the posedge.
  task automatic cycle();
    #1;
    model_comb();
    for (int k = 0; k < NI; k++) begin
      last_gnt[k] = o_gnt[k];
      last_sel[k] = o_sel[k];
      check_eq($sformatf("gnt_i%0d", k), 64'(o_gnt[k]), 64'(e_gnt[k]));
      check_eq($sformatf("sel_i%0d", k), 64'(o_sel[k]), 64'(e_sel[k]));
    end
    @(posedge clk);
    #1;
    model_clock();
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rvalid_i%0d", k), 64'(o_rv[k]), 64'(m_rv[k]));
      check_eq($sformatf("rdata_i%0d", k), o_rd[k], m_rd[k]);
    end
    if (o_rv[0] != '0) begin
      if (exp_q.size() == 0) check_eq("sb_underflow", 64'(o_rv[0]), 64'h0);
      else check_eq("sb_rdata", o_rd[0], exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic expect_gnt(input string tag, input logic [N-1:0] exp_gnt);
    cycle();
    check_eq(tag, 64'(last_gnt[0]), 64'(exp_gnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int wt [N];

  initial begin
    mb[0] = 4; zx[0] = 1'b1;
    mb[1] = 4; zx[1] = 1'b0;
    mb[2] = 1; zx[2] = 1'b1;
    for (int r = 0; r < 32; r++) regs[r] = {$urandom(), $urandom()};
    regs[31] = XZR_PATTERN;

    // Reset with all requests held
    reset  = 1'b1;
    req_d  = 3'b111;
    lock_d = 3'b000;
    addr_d[0] = 5'd2; addr_d[1] = 5'd9; addr_d[2] = 5'd5;
    cycle();
    check_eq("t1_rst_gnt", 64'(last_gnt[0]), 64'h0);
    check_eq("t1_rst_sel", 64'(last_sel[0]), 64'h0);
    cycle();
    check_eq("t1_rst_rvalid", 64'(o_rv[0]), 64'h0);
    check_eq("t1_rst_rdata", o_rd[0], 64'h0);
    reset = 1'b0;

    // Plain round robin
    expect_gnt("t2_g0", 3'b001);
    check_eq("t1_sel", 64'(last_sel[0]), 64'd2);
    check_eq("t2_rd0", o_rd[0], regs[2]);
    expect_gnt("t2_g1", 3'b010);
    check_eq("t2_rd1", o_rd[0], regs[9]);
    expect_gnt("t2_g2", 3'b100);
    check_eq("t2_rd2", o_rd[0], regs[5]);
    expect_gnt("t2_g3", 3'b001);
    check_eq("t2_rv3", 64'(o_rv[0]), 64'b001);

    // Locked burst to the cap, one idle cycle, then the other requester
    do_reset();
    req_d = 3'b011; lock_d = 3'b001;
    for (int i = 0; i < 4; i++) expect_gnt($sformatf("t3_burst%0d", i), 3'b001);
    expect_gnt("t3_idle", 3'b000);
    expect_gnt("t3_other", 3'b010);
    check_eq("t3_rv_other", 64'(o_rv[0]), 64'b010);

    // Single-grant bursts: locked state exits immediately with no grant
    do_reset();
    req_d = 3'b011; lock_d = 3'b001;
    cycle(); check_eq("mb1_g0", 64'(last_gnt[2]), 64'b001);
    cycle(); check_eq("mb1_idle", 64'(last_gnt[2]), 64'b000);
    cycle(); check_eq("mb1_other", 64'(last_gnt[2]), 64'b010);

    // Owner drops lock on its second grant
    do_reset();
    req_d = 3'b011; lock_d = 3'b001;
    expect_gnt("t4a_g0", 3'b001);
    lock_d = 3'b000;
    expect_gnt("t4a_g1", 3'b001);
    expect_gnt("t4a_g2", 3'b010);

    // Owner drops req mid-burst
    do_reset();
    req_d = 3'b011; lock_d = 3'b001;
    expect_gnt("t4b_g0", 3'b001);
    expect_gnt("t4b_g1", 3'b001);
    req_d = 3'b010;
    expect_gnt("t4b_none", 3'b000);
    expect_gnt("t4b_other", 3'b010);

    // Zero register
    do_reset();
    req_d = 3'b001; lock_d = 3'b000; addr_d[0] = 5'd31;
    expect_gnt("t5_g", 3'b001);
    check_eq("t5_rv", 64'(o_rv[0]), 64'b001);
    check_eq("t5_xzr_zero", o_rd[0], 64'h0);
    check_eq("t5_xzr_raw", o_rd[1], XZR_PATTERN);
    req_d = 3'b000;
    cycle();
    check_eq("t5_hold", o_rd[1], XZR_PATTERN);

    // Reset right after a locked grant
    do_reset();
    addr_d[0] = 5'd4;
    req_d = 3'b011; lock_d = 3'b001;
    expect_gnt("t6_g0", 3'b001);
    expect_gnt("t6_g1", 3'b001);
    reset = 1'b1;
    cycle();
    check_eq("t6_rv_drop", 64'(o_rv[0]), 64'h0);
    check_eq("t6_state", 64'(st_a), 64'(ARB));
    check_eq("t6_ptr", 64'(ptr_a), 64'h0);
    reset = 1'b0; lock_d = 3'b000;
    expect_gnt("t6_rearb", 3'b001);

    // Random traffic; requesters hold req/addr until granted by instance A
    do_reset();
    req_d = '0; lock_d = '0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < N; i++) lock_d[i] = ($urandom_range(0, 3) != 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (!reset && last_gnt[0][i]) begin
          check_eq($sformatf("fair_r%0d", i), 64'(wt[i] <= N * (4 + 1)), 64'h1);
          wt[i] = 0;
        end else if (!reset && req_d[i]) begin
          wt[i]++;
        end else begin
          wt[i] = 0;
        end
        if (!req_d[i] || last_gnt[0][i]) begin
          req_d[i]  = ($urandom_range(0, 2) != 0);
          addr_d[i] = 5'($urandom_range(0, 31));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
